// File: rtl/wb_arb.sv
// wb_arb: round-robin arbiter merging EXU results and LSU load data onto one register-file write port
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
module wb_arb (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_exu_valid,
  output logic                  o_exu_ready,
  input  logic [4:0]            i_exu_rd_idx,
  input  logic                  i_exu_wen,
  input  logic [`CPU_WIDTH-1:0] i_exu_res,
  input  logic                  i_lsu_valid,
  output logic                  o_lsu_ready,
  input  logic [4:0]            i_lsu_rd_idx,
  input  logic [`CPU_WIDTH-1:0] i_lsu_res,
  input  logic                  i_stall,
  output logic                  o_rf_wen,
  output logic [4:0]            o_rf_waddr,
  output logic [`CPU_WIDTH-1:0] o_rf_wdata,
  output logic                  o_commit,
  output logic [31:0]           o_commit_cnt
);
  logic                  ptr_q, ptr_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [4:0]            rf_waddr_q, rf_waddr_d;
  logic [`CPU_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  commit_q, commit_d;
  logic [31:0]           commit_cnt_q, commit_cnt_d;
  // grant: reset or stall blocks both; a tie goes to the channel not granted last (ptr_q=1 means LSU last)
  always_comb begin
    o_exu_ready = i_rst_n && !i_stall && i_exu_valid && (!i_lsu_valid || ptr_q);
    o_lsu_ready = i_rst_n && !i_stall && i_lsu_valid && (!i_exu_valid || !ptr_q);
  end
  // next state: capture the granted payload; address and data hold when nothing transfers
  always_comb begin
    ptr_d        = o_lsu_ready ? 1'b1 : o_exu_ready ? 1'b0 : ptr_q;
    rf_wen_d     = o_exu_ready ? (i_exu_wen && |i_exu_rd_idx) : (o_lsu_ready && |i_lsu_rd_idx);
    rf_waddr_d   = o_exu_ready ? i_exu_rd_idx : o_lsu_ready ? i_lsu_rd_idx : rf_waddr_q;
    rf_wdata_d   = o_exu_ready ? i_exu_res : o_lsu_ready ? i_lsu_res : rf_wdata_q;
    commit_d     = o_exu_ready || o_lsu_ready;
    commit_cnt_d = commit_cnt_q + {31'd0, commit_d};
  end
  // state registers; reset points at LSU so EXU wins the first tie
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q        <= 1'b1;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      commit_q     <= 1'b0;
      commit_cnt_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      commit_q     <= commit_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end
  assign o_rf_wen     = rf_wen_q;
  assign o_rf_waddr   = rf_waddr_q;
  assign o_rf_wdata   = rf_wdata_q;
  assign o_commit     = commit_q;
  assign o_commit_cnt = commit_cnt_q;
endmodule
